keypad_scan: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad by driving one column low at a time and reading the active-low rows.
- Debounces one key at a time, then queues key-press codes in a small FIFO. The CPU wrapper reads the FIFO through a valid/ready pop interface.
- Sits between board pins and the peripheral's software-register file.

---
 rtl/keypad_scan_pkg.sv | 22 ++
 rtl/keypad_scan_if.sv | 11 +
 rtl/keypad_scan_fifo.sv | 65 ++++++
 rtl/keypad_scan.sv | 143 ++++++++++++++
 tb/tb_keypad_scan.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its key-code FIFO.
package keypad_scan_pkg;
   localparam int NROW   = 4;
   localparam int NCOL   = 4;
   localparam int CODE_W = 4;

   typedef enum logic [1:0] {
      ST_SCAN  = 2'd0,
      ST_DEB_P = 2'd1,
      ST_HELD  = 2'd2
   } state_e;

   // Lowest-index row reading low; only meaningful when at least one row is low.
   function automatic logic [1:0] lowest_low_row(input logic [NROW-1:0] rows_n);
      logic [1:0] r_sel;
      r_sel = 2'd0;
      for (int r = NROW - 1; r >= 0; r--) begin
         if (!rows_n[r]) r_sel = 2'(r);
      end
      return r_sel;
   endfunction
endpackage

// File: rtl/keypad_scan_if.sv
// Valid/ready pop interface carrying key codes from the scanner to the CPU wrapper.
interface keypad_scan_if;
   import keypad_scan_pkg::*;

   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_fifo.sv
// Small synchronous FIFO; the head output holds the last popped value while empty.
module keypad_fifo #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] last_q, last_d;
   logic              do_push, do_pop;

   assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, single-key debounce FSM
// and a key-code FIFO popped over a valid/ready interface.
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE_N = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic [NCOL-1:0] col_n,
   input  logic [NROW-1:0] row_n,
   keypad_scan_if.master   key_if,
   output logic            key_down,
   output logic            overflow,
   input  logic            ovf_clr
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

   logic [NROW-1:0]   sync1_q, sync2_q;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick;
   state_e            state_q, state_d;
   logic [1:0]        col_q, col_d;
   logic [1:0]        lrow_q, lrow_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              ovf_q, ovf_d;
   logic              push;
   logic [CODE_W-1:0] push_code;
   logic              locked_low;
   logic              fifo_full, fifo_empty, fifo_pop;

   assign tick       = (div_q == DIV_W'(SCAN_DIV - 1));
   assign div_d      = tick ? '0 : div_q + 1'b1;
   assign cnt_inc    = cnt_q + 1'b1;
   assign locked_low = !sync2_q[lrow_q];
   assign col_n      = ~(NCOL'(1) << col_q);
   assign key_down   = (state_q == ST_HELD);
   assign overflow   = ovf_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      lrow_d    = lrow_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_code = {lrow_q, col_q};
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (&sync2_q) begin
                  col_d = col_q + 1'b1;
               end else begin
                  lrow_d    = lowest_low_row(sync2_q);
                  push_code = {lowest_low_row(sync2_q), col_q};
                  if (DEBOUNCE_N == 1) begin
                     push    = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = ST_DEB_P;
                  end
               end
            end
            ST_DEB_P: begin
               if (locked_low) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE_N)) begin
                     push    = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_HELD;
                  end
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (locked_low) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_W'(DEBOUNCE_N)) begin
                     cnt_d   = '0;
                     col_d   = col_q + 1'b1;
                     state_d = ST_SCAN;
                  end
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   // A press is lost only when the FIFO is full and no pop frees a slot this cycle.
   assign fifo_pop = key_if.key_ready && !fifo_empty;
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (push && fifo_full && !fifo_pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         div_q   <= '0;
         state_q <= ST_SCAN;
         col_q   <= '0;
         lrow_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync1_q <= row_n;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         state_q <= state_d;
         col_q   <= col_d;
         lrow_q  <= lrow_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   keypad_fifo #(
      .DATA_W (CODE_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_code),
      .pop_i   (key_if.key_ready),
      .data_o  (key_if.key_code),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign key_if.key_valid = !fifo_empty;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model and a key-code scoreboard.
module tb_keypad_scan;
   import keypad_scan_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic        key_down;
   logic        overflow;
   logic        ovf_clr;
   logic [15:0] keys;
   logic [3:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;

   keypad_scan_if kif ();

   keypad_scan #(
      .SCAN_DIV   (4),
      .DEBOUNCE_N (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .col_n    (col_n),
      .row_n    (row_n),
      .key_if   (kif),
      .key_down (key_down),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls row r low only while column c is driven low.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_down(input logic v, input string tag);
      for (int i = 0; i < 300 && key_down !== v; i++) @(negedge clk);
      chk(tag, key_down, v);
   endtask

   task automatic wait_col(input logic [3:0] v, input string tag);
      for (int i = 0; i < 100 && col_n !== v; i++) @(negedge clk);
      chk(tag, col_n, v);
   endtask

   task automatic pop_expect(input string tag);
      logic [3:0] e;
      for (int i = 0; i < 300 && kif.key_valid !== 1'b1; i++) @(negedge clk);
      chk({tag, "_valid"}, kif.key_valid, 1'b1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      chk({tag, "_code"}, kif.key_code, e);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_col"}, col_n, 4'b1110);
      chk({tag, "_valid"}, kif.key_valid, 1'b0);
      chk({tag, "_code"}, kif.key_code, 4'h0);
      chk({tag, "_down"}, key_down, 1'b0);
      chk({tag, "_ovf"}, overflow, 1'b0);
   endtask

   initial begin
      logic [3:0] exp_col;
      logic [3:0] ovf_codes [5];
      ovf_codes[0] = 4'd5;
      ovf_codes[1] = 4'd6;
      ovf_codes[2] = 4'd7;
      ovf_codes[3] = 4'd8;
      ovf_codes[4] = 4'd10;

      rst           = 1'b0;
      keys          = '0;
      ovf_clr       = 1'b0;
      kif.key_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;

      // Idle scanning: column advances every 4 clocks.
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << ((n / 4) % 4));
         chk("idle_col", col_n, exp_col);
      end
      chk("idle_valid", kif.key_valid, 1'b0);
      chk("idle_ovf", overflow, 1'b0);

      // Clean press of row 2 / col 1.
      keys[9] = 1'b1;
      exp_q.push_back(4'd9);
      wait_down(1'b1, "p9_down");
      chk("p9_valid_with_down", kif.key_valid, 1'b1);
      chk("p9_col_frozen", col_n, 4'b1101);
      pop_expect("p9");
      repeat (30) @(negedge clk);
      chk("p9_hold_down", key_down, 1'b1);
      chk("p9_hold_col", col_n, 4'b1101);
      chk("p9_single", kif.key_valid, 1'b0);
      keys = '0;
      wait_down(1'b0, "p9_release");
      chk("p9_resume_col", col_n, 4'b1011);
      chk("p9_no_release_evt", kif.key_valid, 1'b0);

      // One-tick glitch on row 0 / col 3, then a stable press.
      wait_col(4'b0111, "bnc_col");
      keys[3] = 1'b1;
      repeat (4) @(negedge clk);
      keys[3] = 1'b0;
      repeat (16) @(negedge clk);
      chk("bnc_no_down", key_down, 1'b0);
      chk("bnc_no_evt", kif.key_valid, 1'b0);
      keys[3] = 1'b1;
      exp_q.push_back(4'd3);
      wait_down(1'b1, "bnc_down");
      pop_expect("bnc");
      keys = '0;
      wait_down(1'b0, "bnc_release");

      // Two keys in column 0: lowest row wins, other key reported after release.
      keys[4]  = 1'b1;
      keys[12] = 1'b1;
      exp_q.push_back(4'd4);
      wait_down(1'b1, "two_down");
      pop_expect("two_first");
      repeat (8) @(negedge clk);
      chk("two_only_one", kif.key_valid, 1'b0);
      keys[4] = 1'b0;
      exp_q.push_back(4'd12);
      wait_down(1'b0, "two_rel_first");
      pop_expect("two_second");
      keys = '0;
      wait_down(1'b0, "two_rel_all");

      // Fill the FIFO with key_ready low, then overflow.
      for (int i = 0; i < 5; i++) begin
         keys[ovf_codes[i]] = 1'b1;
         if (i < 4) exp_q.push_back(ovf_codes[i]);
         wait_down(1'b1, "ovf_down");
         keys = '0;
         wait_down(1'b0, "ovf_up");
         if (i == 3) chk("ovf_not_yet", overflow, 1'b0);
      end
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_valid", kif.key_valid, 1'b1);
      ovf_clr = 1'b1;
      keys[2] = 1'b1;
      wait_down(1'b1, "ovf6_down");
      ovf_clr = 1'b0;
      chk("ovf_set_wins", overflow, 1'b1);
      keys = '0;
      wait_down(1'b0, "ovf6_up");
      for (int i = 0; i < 4; i++) pop_expect("ovf_pop");
      chk("ovf_drained", kif.key_valid, 1'b0);
      chk("ovf_sticky", overflow, 1'b1);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
      chk("empty_pop_valid", kif.key_valid, 1'b0);
      chk("empty_hold_code", kif.key_code, 4'd8);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", overflow, 1'b0);

      // Reset in the middle of debouncing.
      wait_col(4'b1110, "rdeb_col");
      keys[0] = 1'b1;
      repeat (5) @(negedge clk);
      rst  = 1'b0;
      keys = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rdeb");
      rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("rdeb_no_evt", kif.key_valid, 1'b0);
      chk("rdeb_no_down", key_down, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
